// File: rtl/vector_checker.sv
// Steps a vector ROM through an external combinational gate DUT and flags mismatching results.
// Optional build macro VECCHK_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module vector_checker #(
    parameter int NVEC   = 136,
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [9:0]  vec_addr,
    input  logic [39:0] vec_data,
    output logic [3:0]  a,
    output logic [3:0]  b,
    input  logic [31:0] dut_y,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [9:0]  fail_idx,
    output logic [7:0]  err_count,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_SETTLE = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [9:0] LAST_VEC   = 10'(NVEC - 1);
    localparam logic [3:0] TIMER_INIT = 4'(SETTLE - 1);

    state_t       state_q, state_d;
    logic [9:0]   vn_q, vn_d;
    logic [3:0]   timer_q, timer_d;
    logic [39:0]  vec_q, vec_d;
    logic         fail_q, fail_d;
    logic [9:0]   fail_idx_q, fail_idx_d;
    logic [7:0]   err_q, err_d;
    logic         mismatch;
    logic         stop_now;

    // Case inequality so an X/Z on the gate outputs is reported instead of silently passing.
    assign mismatch = (dut_y !== vec_q[31:0]);

`ifdef VECCHK_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            vn_q       <= 10'd0;
            timer_q    <= 4'd0;
            vec_q      <= 40'd0;
            fail_q     <= 1'b0;
            fail_idx_q <= 10'd0;
            err_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            vn_q       <= vn_d;
            timer_q    <= timer_d;
            vec_q      <= vec_d;
            fail_q     <= fail_d;
            fail_idx_q <= fail_idx_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        vn_d       = vn_q;
        timer_d    = timer_q;
        vec_d      = vec_q;
        fail_d     = 1'b0;
        fail_idx_d = fail_idx_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    vn_d       = 10'd0;
                    err_d      = 8'd0;
                    fail_idx_d = 10'd0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                // ROM word arrives one cycle after the address; a/b change from the next cycle.
                vec_d   = vec_data;
                timer_d = TIMER_INIT;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (timer_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    fail_d     = 1'b1;
                    fail_idx_d = vn_q;
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
                if (vn_q == LAST_VEC || stop_now) begin
                    state_d = S_DONE;
                end else begin
                    vn_d    = vn_q + 10'd1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign vec_addr  = vn_q;
    assign a         = vec_q[39:36];
    assign b         = vec_q[35:32];
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign fail      = fail_q;
    assign fail_idx  = fail_idx_q;
    assign err_count = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vector_checker.sv
// Bench for vector_checker: a 4-vector checker with a hand-written ROM and a 300-vector checker
// with every expected word inverted, both driving a behavioural 4-bit gate model.
module tb_vector_checker;

`ifdef VECCHK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic        reset, start_s, start_b;
  logic [9:0]  vec_addr_s, vec_addr_b, fail_idx_s, fail_idx_b;
  logic [39:0] vec_data_s, vec_data_b;
  logic [3:0]  a_s, b_s, a_b, b_b;
  logic [31:0] dut_y_s, dut_y_b;
  logic        busy_s, done_s, fail_s, busy_b, done_b, fail_b;
  logic [7:0]  err_s, err_b;
  logic [2:0]  dbg_s, dbg_b;

  logic [39:0] rom_s [4];
  logic [39:0] rom_b [300];

  function automatic logic [31:0] gates(input logic [3:0] x, input logic [3:0] y);
    return {x, ~x, x & y, ~(x & y), x | y, ~(x | y), x ^ y, ~(x ^ y)};
  endfunction

  assign dut_y_s = gates(a_s, b_s);
  assign dut_y_b = gates(a_b, b_b);

  always @(posedge clk) vec_data_s <= rom_s[vec_addr_s[1:0]];
  always @(posedge clk) vec_data_b <= rom_b[int'(vec_addr_b) % 300];

  vector_checker #(.NVEC(4), .SETTLE(1)) u_small (
    .clk(clk), .reset(reset), .start(start_s), .vec_addr(vec_addr_s), .vec_data(vec_data_s),
    .a(a_s), .b(b_s), .dut_y(dut_y_s), .busy(busy_s), .done(done_s), .fail(fail_s),
    .fail_idx(fail_idx_s), .err_count(err_s), .dbg_state(dbg_s)
  );

  vector_checker #(.NVEC(300), .SETTLE(2)) u_big (
    .clk(clk), .reset(reset), .start(start_b), .vec_addr(vec_addr_b), .vec_data(vec_data_b),
    .a(a_b), .b(b_b), .dut_y(dut_y_b), .busy(busy_b), .done(done_b), .fail(fail_b),
    .fail_idx(fail_idx_b), .err_count(err_b), .dbg_state(dbg_b)
  );

  int checks = 0;
  int errors = 0;
  int vmax = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_big_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pops an expected failing index for every fail pulse either checker presents.
  task automatic monitor();
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (fail_s) begin
          if (exp_q.size() == 0) check("small_unexpected_fail", 32'(fail_s), 32'd0);
          else begin
            e = exp_q.pop_front();
            check("small_fail_idx", 32'(fail_idx_s), 32'(e));
          end
        end
        if (fail_b) begin
          if (exp_big_q.size() == 0) check("big_unexpected_fail", 32'(fail_b), 32'd0);
          else begin
            e = exp_big_q.pop_front();
            check("big_fail_idx", 32'(fail_idx_b), 32'(e));
          end
        end
        if (int'(vec_addr_s) > vmax) vmax = int'(vec_addr_s);
      end
    end
  endtask

  task automatic run_small(input int budget, output int cyc);
    int t0;
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    t0 = cyc_cnt;
    while (!done_s && (cyc_cnt - t0) < budget) @(negedge clk);
    cyc = cyc_cnt - t0;
  endtask

  task automatic rom_clean();
    rom_s[0] = 40'h353C1E7869;  // a=3 b=5
    rom_s[1] = 40'hF0F00FF0F0;  // a=F b=0
    rom_s[2] = 40'hA6A52DE1C3;  // a=A b=6
    rom_s[3] = 40'h000F0F0F0F;  // a=0 b=0
  endtask

  initial begin
    int cyc, n, t0;
    logic [3:0] ta, tb;
    reset = 1'b1; start_s = 1'b0; start_b = 1'b0;
    rom_clean();
    for (int i = 0; i < 300; i++) begin
      ta = 4'(i * 7 + 3);
      tb = 4'(i * 5 + 1);
      rom_b[i] = {ta, tb, ~gates(ta, tb)};
    end
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_s), 32'd0);
    check("rst_done", 32'(done_s), 32'd0);
    check("rst_err", 32'(err_s), 32'd0);
    check("rst_state", 32'(dbg_s), 32'd0);
    check("rst_big_state", 32'(dbg_b), 32'd0);
    reset = 1'b0;

    // Clean run: 4 vectors x 4 cycles.
    run_small(64, cyc);
    check("clean_cycles", 32'(cyc), 32'd16);
    check("clean_done", 32'(done_s), 32'd1);
    check("clean_busy", 32'(busy_s), 32'd0);
    @(negedge clk);
    check("clean_err", 32'(err_s), 32'd0);

    // Expected ynand of vector 2 corrupted.
    rom_s[2] = rom_s[2] ^ 40'h0000010000;
    exp_q.push_back(10'd2);
    run_small(64, cyc);
    check("c2_cycles", 32'(cyc), STOP ? 32'd12 : 32'd16);
    @(negedge clk);
    check("c2_err", 32'(err_s), 32'd1);
    check("c2_fail_idx", 32'(fail_idx_s), 32'd2);
    check("c2_queue_empty", 32'(exp_q.size()), 32'd0);
    rom_clean();

    // Reset in SETTLE of vector 1.
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    n = 0;
    while (!(dbg_s == 3'd3 && vec_addr_s == 10'd1) && n < 40) begin @(negedge clk); n++; end
    check("mid_settle_found", 32'(n < 40), 32'd1);
    check("mid_a_before", 32'(a_s), 32'hF);
    reset = 1'b1;
    @(negedge clk);
    check("mid_state", 32'(dbg_s), 32'd0);
    check("mid_busy", 32'(busy_s), 32'd0);
    check("mid_done", 32'(done_s), 32'd0);
    check("mid_fail", 32'(fail_s), 32'd0);
    check("mid_vec_addr", 32'(vec_addr_s), 32'd0);
    check("mid_ab", 32'({a_s, b_s}), 32'd0);
    check("mid_err", 32'(err_s), 32'd0);
    check("mid_fail_idx", 32'(fail_idx_s), 32'd0);
    reset = 1'b0;
    run_small(64, cyc);
    check("rerun_cycles", 32'(cyc), 32'd16);
    @(negedge clk);
    check("rerun_err", 32'(err_s), 32'd0);

    // Start pulsed while busy, with a mismatch at vector 1.
    rom_s[1] = rom_s[1] ^ 40'h0000000001;
    exp_q.push_back(10'd1);
    vmax = 0;
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    t0 = cyc_cnt;
    n = 0;
    while (dbg_s != 3'd2 && n < 20) begin @(negedge clk); n++; end
    check("busy_in_load", 32'(dbg_s), 32'd2);
    start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    check("busy_start_vn", 32'(vec_addr_s), 32'd0);
    check("busy_start_state", 32'(dbg_s), 32'd3);
    while (!done_s && (cyc_cnt - t0) < 64) @(negedge clk);
    check("busy_cycles", 32'(cyc_cnt - t0), STOP ? 32'd8 : 32'd16);
    check("busy_vmax", 32'(vmax), STOP ? 32'd1 : 32'd3);
    @(negedge clk);
    check("busy_err", 32'(err_s), 32'd1);
    check("busy_fail_idx", 32'(fail_idx_s), 32'd1);

    // Start held high in DONE restarts a run.
    exp_q.push_back(10'd1);
    start_s = 1'b1;
    @(negedge clk);
    check("hold_done_drop", 32'(done_s), 32'd0);
    check("hold_busy", 32'(busy_s), 32'd1);
    check("hold_err_clear", 32'(err_s), 32'd0);
    @(negedge clk); start_s = 1'b0;
    n = 0;
    while (!done_s && n < 64) begin @(negedge clk); n++; end
    check("hold_done", 32'(done_s), 32'd1);
    @(negedge clk);
    check("hold_err", 32'(err_s), 32'd1);
    check("hold_queue_empty", 32'(exp_q.size()), 32'd0);
    rom_clean();

    // 300 inverted vectors: counter saturates, every vector still pulses fail.
    for (int i = 0; i < 300; i++) if (!STOP || i == 0) exp_big_q.push_back(10'(i));
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    t0 = cyc_cnt;
    while (!done_b && (cyc_cnt - t0) < 2000) @(negedge clk);
    check("big_cycles", 32'(cyc_cnt - t0), STOP ? 32'd5 : 32'd1500);
    @(negedge clk);
    check("big_err", 32'(err_b), STOP ? 32'd1 : 32'd255);
    check("big_fail_idx_final", 32'(fail_idx_b), STOP ? 32'd0 : 32'd299);
    check("big_queue_empty", 32'(exp_big_q.size()), 32'd0);
    check("big_busy", 32'(busy_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_checker.md
VECTOR_CHECKER -- requirements
Module: vector_checker

Interface
REQ-001 Parameter NVEC, default 136, number of test vectors stepped per run (1..1024).
REQ-002 Parameter SETTLE, default 1, cycles between applying a/b and sampling DUT outputs (1..15).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a run; sampled only in IDLE or DONE.
REQ-006 vec_addr  output  10  vector ROM address (current index vn).
REQ-007 vec_data  input  40  ROM word {a, b, ye, ynote, yande, ynande, yore, ynore, yxore, ynxore}, MSB first, valid one cycle after vec_addr.
REQ-008 a, b  output  4 each  operands driven to the gate DUT.
REQ-009 dut_y  input  32  DUT results {y, ynot, yand, ynand, yor, ynor, yxor, ynxor}, MSB first.
REQ-010 busy  output  1  high in every state except IDLE and DONE.
REQ-011 done  output  1  high while in DONE.
REQ-012 fail  output  1  one-cycle pulse per mismatching vector.
REQ-013 fail_idx  output  10  index of most recent mismatching vector.
REQ-014 err_count  output  8  mismatches this run, saturating.

Function
REQ-015 FSM states IDLE, FETCH, LOAD, SETTLE, CHECK, DONE.
REQ-016 IDLE/DONE + start=1 -> FETCH next cycle; vn, err_count, fail_idx cleared to 0; done drops.
REQ-017 FETCH: vec_addr=vn -> LOAD.
REQ-018 LOAD: vec_data captured in 40-bit vector register; a=reg[39:36], b=reg[35:32] from next cycle, held until next LOAD -> SETTLE, timer=SETTLE-1.
REQ-019 SETTLE: timer decrements; exits to CHECK when timer==0, so dut_y is sampled exactly SETTLE cycles after a/b change.
REQ-020 CHECK: mismatch if dut_y differs from reg[31:0] in any bit (X/Z on dut_y counts as mismatch in simulation).
REQ-021 Mismatch: fail=1 next cycle for one cycle, fail_idx=vn, err_count+1 saturating at 255.
REQ-022 CHECK with vn==NVEC-1 -> DONE; else vn+1 -> FETCH.
REQ-023 Cost per vector: 3+SETTLE cycles; run = NVEC*(3+SETTLE) cycles from start accepted to done high.
REQ-024 start while busy is ignored; start held high in DONE restarts a run.
REQ-025 err_count, fail_idx hold their values in DONE until next start.

Reset
REQ-026 reset=1 at any clock edge, including mid-run: state IDLE, vn=0, timer=0, vector register=0, a=b=0, vec_addr=0, busy=0, done=0, fail=0, fail_idx=0, err_count=0.
REQ-027 reset overrides start in the same cycle.

Configuration
REQ-028 Macro VECCHK_STOP_ON_FAIL_EN: when defined, CHECK with a mismatch goes directly to DONE (fail still pulses, err_count=1, fail_idx=failing index); when undefined, the run always covers all NVEC vectors.

Verification
REQ-029 NVEC=4, SETTLE=1, ROM matching a correct gates model, start pulse -> done high 16 cycles after start accepted, err_count=0, fail never asserted.
REQ-030 Same, ROM expected ynand at index 2 corrupted -> exactly one fail pulse, fail_idx=2, err_count=1, run still completes (macro undefined).
REQ-031 NVEC=300, every expected word inverted -> err_count stops at 255, fail pulses 300 times, done asserts.
REQ-032 reset asserted in SETTLE of vector 1 -> next cycle all outputs at reset values; subsequent start reruns from vn=0.
REQ-033 start pulsed while busy -> no effect on vn or err_count; start held in DONE -> new run begins, err_count cleared.
REQ-034 VECCHK_STOP_ON_FAIL_EN defined, mismatch at index 1 of 4 -> DONE entered the cycle after CHECK of index 1, vec_addr never reaches 2.
